// File: rtl/updown_mon_pkg.sv
`default_nettype none
// ============================================================================
// updown_mon_pkg : event codes, monitor FSM states and event record
// Revision: 1.0
// ============================================================================
package updown_mon_pkg;

    localparam logic [1:0] EVT_DIR_CHANGE = 2'b00;
    localparam logic [1:0] EVT_WRAP       = 2'b01;
    localparam logic [1:0] EVT_STEP_ERR   = 2'b10;
    localparam logic [1:0] EVT_RESYNC     = 2'b11;

    // Count field sized for the widest supported bus; narrower monitors zero-extend.
    localparam int EVT_COUNT_W = 32;

    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [1:0]             code;
        logic [EVT_COUNT_W-1:0] count;
    } evt_t;

endpackage
`default_nettype wire

// File: rtl/updown_mon_evt_q.sv
`default_nettype none
// ============================================================================
// updown_mon_evt_q : event holding stage; single register, or a 4-entry FIFO
//                    when UPDOWN_MON_EVT_FIFO_EN is defined
// Revision: 1.0
// ============================================================================
module updown_mon_evt_q
    import updown_mon_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  evt_t push_evt,
    input  logic pop,
    output logic valid,
    output evt_t head,
    output logic full,
    output logic drop
);

    logic pop_ok;
    logic accept;

    assign pop_ok = pop && valid;
    assign accept = push && (!full || pop_ok);
    assign drop   = push && full && !pop_ok;

`ifdef UPDOWN_MON_EVT_FIFO_EN
    localparam int DEPTH = 4;

    evt_t       mem [DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fill;

    assign valid = (fill != 3'd0);
    assign full  = (fill == 3'(DEPTH));
    assign head  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_evt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 2'd1;
            if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
            case ({accept, pop_ok})
                2'b10:   fill <= fill + 3'd1;
                2'b01:   fill <= fill - 3'd1;
                default: fill <= fill;
            endcase
        end
    end
`else
    evt_t held;
    logic held_valid;

    assign valid = held_valid;
    assign full  = held_valid;
    assign head  = held;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held       <= '0;
            held_valid <= 1'b0;
        end else if (accept) begin
            held       <= push_evt;
            held_valid <= 1'b1;
        end else if (pop_ok) begin
            held_valid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/updown_count_monitor.sv
`default_nettype none
// ============================================================================
// updown_count_monitor : infers counter direction, checks step legality and
//                        reports events; UPDOWN_MON_EVT_FIFO_EN selects a FIFO
// Revision: 1.0
// ============================================================================
module updown_count_monitor
    import updown_mon_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RUN_W     = 16,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             dir,
    output logic [RUN_W-1:0] run_len,
    output logic [7:0]       err_cnt,
    output logic [7:0]       drop_cnt,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [WIDTH-1:0] evt_count
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [3:0]       LIMIT    = 4'(ERR_LIMIT);

    mon_state_t       state, state_nxt;
    logic [WIDTH-1:0] prev, diff;
    logic             dir_nxt;
    logic [RUN_W-1:0] run_nxt;
    logic [3:0]       bad_run, bad_nxt, bad_inc;
    logic             up_step, dn_step, same_dir;
    logic             err_inc, evt_push, evt_pop, evt_drop, evt_full;
    evt_t             evt_new, evt_head;
    logic             unused_bits;

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        run_nxt   = run_len;
        bad_nxt   = bad_run;
        err_inc   = 1'b0;
        evt_push  = 1'b0;
        evt_new   = '0;
        diff      = count_in - prev;
        up_step   = (diff == ONE);
        dn_step   = (diff == ALL_ONES);
        same_dir  = dir ? up_step : dn_step;
        bad_inc   = bad_run + 4'd1;
        if (sample_en) begin
            case (state)
                UNSYNC: state_nxt = ACQUIRE;
                ACQUIRE: begin
                    if (up_step || dn_step) begin
                        state_nxt = LOCKED;
                        dir_nxt   = up_step;
                        run_nxt   = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (same_dir) begin
                        if (run_len != '1) run_nxt = run_len + RUN_W'(1);
                        bad_nxt = '0;
                        // A same-direction step out of the extreme value is a modulo wrap.
                        if (dir ? (prev == ALL_ONES) : (prev == '0)) begin
                            evt_push     = 1'b1;
                            evt_new.code = EVT_WRAP;
                        end
                    end else if (up_step || dn_step) begin
                        evt_push     = 1'b1;
                        evt_new.code = EVT_DIR_CHANGE;
                        dir_nxt      = ~dir;
                        run_nxt      = RUN_W'(1);
                        bad_nxt      = '0;
                    end else if (diff != '0) begin
                        err_inc  = 1'b1;
                        evt_push = 1'b1;
                        if (bad_inc == LIMIT) begin
                            evt_new.code = EVT_RESYNC;
                            state_nxt    = ACQUIRE;
                            run_nxt      = '0;
                            bad_nxt      = '0;
                        end else begin
                            evt_new.code = EVT_STEP_ERR;
                            bad_nxt      = bad_inc;
                        end
                    end
                end
                default: state_nxt = UNSYNC;
            endcase
        end
        evt_new.count = EVT_COUNT_W'(count_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= UNSYNC;
            locked   <= 1'b0;
            prev     <= '0;
            dir      <= 1'b1;
            run_len  <= '0;
            bad_run  <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (sample_en) prev <= count_in;
            state   <= state_nxt;
            locked  <= (state_nxt == LOCKED);
            dir     <= dir_nxt;
            run_len <= run_nxt;
            bad_run <= bad_nxt;
            if (err_inc && (err_cnt != 8'hFF))   err_cnt  <= err_cnt + 8'd1;
            if (evt_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign evt_pop = evt_valid && evt_ready;

    updown_mon_evt_q u_evt_q (
        .clk      (clk),
        .reset    (reset),
        .push     (evt_push),
        .push_evt (evt_new),
        .pop      (evt_pop),
        .valid    (evt_valid),
        .head     (evt_head),
        .full     (evt_full),
        .drop     (evt_drop)
    );

    assign evt_code    = evt_head.code;
    assign evt_count   = evt_head.count[WIDTH-1:0];
    // Upper count bits are zero-extension only; full is folded into drop.
    assign unused_bits = ^{evt_head.count, evt_full};

endmodule
`default_nettype wire

// File: tb/tb_updown_count_monitor.sv
`default_nettype none
// ============================================================================
// tb_updown_count_monitor : vector table, corner sequences and randomized
//                           run against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_updown_count_monitor;

    localparam int WIDTH     = 8;
    localparam int RUN_W     = 16;
    localparam int ERR_LIMIT = 3;
`ifdef UPDOWN_MON_EVT_FIFO_EN
    localparam int QCAP = 4;
`else
    localparam int QCAP = 1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sample_en = 1'b0;
    logic [WIDTH-1:0] count_in = '0;
    logic             evt_ready = 1'b0;
    logic             locked, dir, evt_valid;
    logic [RUN_W-1:0] run_len;
    logic [7:0]       err_cnt, drop_cnt;
    logic [1:0]       evt_code;
    logic [WIDTH-1:0] evt_count;

    always #5 clk = ~clk;

    updown_count_monitor #(.WIDTH(WIDTH), .RUN_W(RUN_W), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .count_in  (count_in),
        .locked    (locked),
        .dir       (dir),
        .run_len   (run_len),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_count (evt_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit se, input logic [7:0] c, input bit rdy);
        @(negedge clk);
        sample_en = se;
        count_in  = c;
        evt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"},   int'(locked), 0);
        check({tag, "_dir"},      int'(dir), 1);
        check({tag, "_run"},      int'(run_len), 0);
        check({tag, "_err"},      int'(err_cnt), 0);
        check({tag, "_drop"},     int'(drop_cnt), 0);
        check({tag, "_evtvalid"}, int'(evt_valid), 0);
        check({tag, "_evtcode"},  int'(evt_code), 0);
        check({tag, "_evtcount"}, int'(evt_count), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        sample_en = 1'b0;
        evt_ready = 1'b0;
        #2;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         rst;
        bit         se;
        logic [7:0] cnt;
        bit         rdy;
        bit         lk;
        bit         dr;
        int         run;
        bit         ev;
        logic [1:0] code;
        logic [7:0] ecnt;
        int         err;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit rst, input bit se, input logic [7:0] cnt, input bit lk,
                       input bit dr, input int run, input bit ev, input logic [1:0] code,
                       input logic [7:0] ecnt, input int err);
        vec_t v;
        v.rst = rst; v.se = se; v.cnt = cnt; v.rdy = 1'b1; v.lk = lk; v.dr = dr;
        v.run = run; v.ev = ev; v.code = code; v.ecnt = ecnt; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic add_rst();
        add(1, 0, 8'h00, 0, 0, 0, 0, 2'b00, 8'h00, 0);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int code; int cnt; } mevt_t;
    mevt_t m_q[$];
    int m_phase, m_prev, m_dir, m_run, m_err, m_drop, m_bad;

    task automatic m_reset();
        m_phase = 0; m_prev = 0; m_dir = 1; m_run = 0;
        m_err = 0; m_drop = 0; m_bad = 0;
        m_q.delete();
    endtask

    task automatic m_step(input bit se, input int c, input bit rdy);
        int d, stp, code;
        bit has;
        mevt_t e;
        has = 0; code = 0;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (se) begin
            d   = (c - m_prev + 256) % 256;
            stp = (d == 1) ? 1 : ((d == 255) ? -1 : 0);
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (stp != 0) begin
                    m_phase = 2; m_dir = (stp == 1) ? 1 : 0; m_run = 1;
                end
            end else if (d != 0) begin
                if (stp != 0 && ((stp == 1) == (m_dir == 1))) begin
                    m_run = (m_run < 65535) ? m_run + 1 : 65535;
                    m_bad = 0;
                    if (c - m_prev != stp) begin has = 1; code = 1; end
                end else if (stp != 0) begin
                    has = 1; code = 0; m_dir = 1 - m_dir; m_run = 1; m_bad = 0;
                end else begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    m_bad++;
                    has = 1;
                    if (m_bad == ERR_LIMIT) begin
                        code = 3; m_phase = 1; m_run = 0; m_bad = 0;
                    end else begin
                        code = 2;
                    end
                end
            end
            m_prev = c;
        end
        if (has) begin
            if (m_q.size() < QCAP) begin
                e.code = code; e.cnt = c; m_q.push_back(e);
            end else begin
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, trend;
        bit se, rdy;
        logic [7:0] c, last;

        // Up count from reset, wrap up, reversal, wrap down, hold, error/resync.
        add_rst();
        add(0, 1, 8'h00, 0, 1, 0, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h01, 1, 1, 1, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h02, 1, 1, 2, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h03, 1, 1, 3, 0, 2'b00, 8'h00, 0);
        add_rst();
        add(0, 1, 8'hFD, 0, 1, 0, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'hFE, 1, 1, 1, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'hFF, 1, 1, 2, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h00, 1, 1, 3, 1, 2'b01, 8'h00, 0);
        add(0, 1, 8'h01, 1, 1, 4, 0, 2'b00, 8'h00, 0);
        add(0, 0, 8'h77, 1, 1, 4, 0, 2'b00, 8'h00, 0);
        add_rst();
        add(0, 1, 8'h0E, 0, 1, 0, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h0F, 1, 1, 1, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h10, 1, 1, 2, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h0F, 1, 0, 1, 1, 2'b00, 8'h0F, 0);
        add(0, 1, 8'h0E, 1, 0, 2, 0, 2'b00, 8'h00, 0);
        add_rst();
        add(0, 1, 8'h02, 0, 1, 0, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h01, 1, 0, 1, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h00, 1, 0, 2, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'hFF, 1, 0, 3, 1, 2'b01, 8'hFF, 0);
        add(0, 1, 8'hFF, 1, 0, 3, 0, 2'b00, 8'h00, 0);
        add_rst();
        add(0, 1, 8'h1F, 0, 1, 0, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h20, 1, 1, 1, 0, 2'b00, 8'h00, 0);
        add(0, 1, 8'h25, 1, 1, 1, 1, 2'b10, 8'h25, 1);
        add(0, 1, 8'h30, 1, 1, 1, 1, 2'b10, 8'h30, 2);
        add(0, 1, 8'h40, 0, 1, 0, 1, 2'b11, 8'h40, 3);
        add(0, 1, 8'h41, 1, 1, 1, 0, 2'b00, 8'h00, 3);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                apply_reset();
            end else begin
                step(vecs[i].se, vecs[i].cnt, vecs[i].rdy);
                check($sformatf("v%0d_locked", i),   int'(locked), int'(vecs[i].lk));
                check($sformatf("v%0d_dir", i),      int'(dir), int'(vecs[i].dr));
                check($sformatf("v%0d_run", i),      int'(run_len), vecs[i].run);
                check($sformatf("v%0d_err", i),      int'(err_cnt), vecs[i].err);
                check($sformatf("v%0d_drop", i),     int'(drop_cnt), 0);
                check($sformatf("v%0d_evtvalid", i), int'(evt_valid), int'(vecs[i].ev));
                if (vecs[i].ev) begin
                    check($sformatf("v%0d_evtcode", i),  int'(evt_code), int'(vecs[i].code));
                    check($sformatf("v%0d_evtcount", i), int'(evt_count), int'(vecs[i].ecnt));
                end
            end
        end

        // Back-pressure: two reversals with the consumer stalled.
        apply_reset();
        step(1, 8'h10, 0);
        step(1, 8'h11, 0);
        step(1, 8'h10, 0);
        check("bp_first_valid", int'(evt_valid), 1);
        check("bp_first_count", int'(evt_count), 'h10);
        step(1, 8'h11, 0);
        check("bp_dir", int'(dir), 1);
        check("bp_held_code", int'(evt_code), 0);
        check("bp_held_count", int'(evt_count), 'h10);
        check("bp_drop", int'(drop_cnt), (QCAP == 1) ? 1 : 0);
        step(0, 8'h11, 0);
        check("bp_stable_count", int'(evt_count), 'h10);
        check("bp_stable_valid", int'(evt_valid), 1);
        step(0, 8'h11, 1);
        check("bp_second_valid", int'(evt_valid), (QCAP == 1) ? 0 : 1);
        if (QCAP > 1) check("bp_second_count", int'(evt_count), 'h11);
        step(0, 8'h11, 1);
        check("bp_drained", int'(evt_valid), 0);

        // Asynchronous reset with an event pending.
        apply_reset();
        step(1, 8'h50, 0);
        step(1, 8'h51, 0);
        step(1, 8'h50, 0);
        check("ar_pending", int'(evt_valid), 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        @(negedge clk);
        reset = 1'b0;
        step(0, 8'h50, 1);
        check("ar_event_lost", int'(evt_valid), 0);

        // Randomized run against the model.
        apply_reset();
        m_reset();
        last = 8'h00;
        trend = 1;
        for (int n = 0; n < 4000; n++) begin
            se  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) trend = -trend;
            r = $urandom_range(0, 15);
            if (r < 10)      c = last + 8'(trend);
            else if (r < 11) c = last - 8'(trend);
            else if (r < 13) c = last;
            else             c = 8'($urandom_range(0, 255));
            if (se) last = c;
            m_step(se, int'(c), rdy);
            step(se, c, rdy);
            check("rnd_locked", int'(locked), (m_phase == 2) ? 1 : 0);
            check("rnd_dir", int'(dir), m_dir);
            check("rnd_run", int'(run_len), m_run);
            check("rnd_err", int'(err_cnt), m_err);
            check("rnd_drop", int'(drop_cnt), m_drop);
            check("rnd_evtvalid", int'(evt_valid), (m_q.size() > 0) ? 1 : 0);
            if (m_q.size() > 0) begin
                check("rnd_evtcode", int'(evt_code), m_q[0].code);
                check("rnd_evtcount", int'(evt_count), m_q[0].cnt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_count_monitor.md
Name: updown_count_monitor

Overview:
- Sink side of the up/down counter interface: consumes the WIDTH-bit count bus each sampled cycle and infers direction.
- Checks step legality (±1, hold, modulo wrap) and reports direction changes, wraps and step errors as handshaked events.
- Sits beside any n-bit up/down counter as an in-system checker; also serves as a self-checking element in counter benches.

Parameters:
WIDTH, 8, width of observed count bus
RUN_W, 16, width of run-length counter
ERR_LIMIT, 3, consecutive illegal steps in LOCKED before forced resync (1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
sample_en  input  1  count_in is a valid sample this cycle
count_in  input  WIDTH  observed counter value
locked  output  1  monitor has a direction lock
dir  output  1  inferred direction: 1 = up, 0 = down
run_len  output  RUN_W  consecutive same-direction steps, saturating
err_cnt  output  8  total illegal steps, saturating at 255
drop_cnt  output  8  events lost to back-pressure, saturating at 255
evt_valid  output  1  event available
evt_ready  input  1  consumer accepts event
evt_code  output  2  00 DIR_CHANGE, 01 WRAP, 10 STEP_ERR, 11 RESYNC
evt_count  output  WIDTH  count_in value that caused the event

Behaviour:
- Reset (async assert, sync release): state=UNSYNC, locked=0, dir=1, run_len=0, err_cnt=0, drop_cnt=0, evt_valid=0, evt_code=0, evt_count=0, prev=0, bad_run=0. Reset mid-operation discards any pending event.
- Only cycles with sample_en=1 advance the FSM. diff = (count_in - prev) mod 2^WIDTH. prev <= count_in on every sample.
- UNSYNC: first sample loads prev -> ACQUIRE.
- ACQUIRE:
  - diff=1 -> LOCKED, dir=1, run_len=1.
  - diff=all-ones (-1) -> LOCKED, dir=0, run_len=1.
  - Any other diff -> stay in ACQUIRE.
  - No events are emitted in ACQUIRE.
- LOCKED, classified against current dir:
  - Same-direction ±1: run_len++ (saturate), bad_run=0. If (dir=1, prev=max, count_in=0) or (dir=0, prev=0, count_in=max), emit WRAP.
  - Opposite-direction ±1: emit DIR_CHANGE, dir flips, run_len=1, bad_run=0. A reversal across the wrap boundary emits DIR_CHANGE only.
  - diff=0 (hold): no state change, no event, bad_run unchanged.
  - Otherwise: emit STEP_ERR, err_cnt++, bad_run++. If bad_run reaches ERR_LIMIT, emit RESYNC instead of STEP_ERR -> ACQUIRE, locked=0, run_len=0, bad_run=0. err_cnt still increments.
- locked is a registered output equal to (state==LOCKED).
- All outputs are registered; an event appears on evt_* one cycle after the triggering sample.
- Event port: one-entry output register. Transfer occurs when evt_valid && evt_ready.
  - New event while the register is empty, or being popped the same cycle: load it.
  - New event while the register is occupied and not popped: drop the new event, drop_cnt++.
  - evt_code and evt_count are stable while evt_valid && !evt_ready.

Optional Feature:
- Macro UPDOWN_MON_EVT_FIFO_EN.
- Defined: event register replaced by a 4-entry FIFO. Drops occur only when the FIFO is full and not popped in the same cycle. A simultaneous push and pop on a full FIFO is legal. FIFO order equals event order.
- Undefined: single-entry register as above.

Decomposition:
- Package updown_mon_pkg holds:
  - event code constants EVT_DIR_CHANGE, EVT_WRAP, EVT_STEP_ERR, EVT_RESYNC;
  - FSM state enum (UNSYNC, ACQUIRE, LOCKED);
  - event struct {code, count}.
- One sub-module, updown_mon_evt_q: the event holding stage (register or FIFO under the macro), with push/pop/full/drop interface.

Test Plan:
- Reset, then samples 0,1,2,3 with evt_ready=1 -> locked=1 after 2nd sample, dir=1, run_len=3, no events.
- Up-count 8'hFE,8'hFF,8'h00 -> one WRAP event with evt_count=8'h00; run_len keeps incrementing.
- Up to 8'h10, then 8'h0F -> DIR_CHANGE with evt_count=8'h0F, dir=0, run_len=1. Then 8'h01,8'h00,8'hFF -> WRAP with evt_count=8'hFF.
- While locked up at 8'h20, samples 8'h25, 8'h30, 8'h40 -> STEP_ERR, STEP_ERR, RESYNC; err_cnt=3, locked=0. Then 8'h41 -> relocked dir=1.
- evt_ready=0 with two DIR_CHANGE events -> first event held stable, drop_cnt=1. With UPDOWN_MON_EVT_FIFO_EN, both events are delivered in order and drop_cnt=0.
- Assert reset mid-run with evt_valid=1 -> all outputs return to reset values asynchronously, and the pending event is lost.
